// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline: PC-source encodings, IF state
// encoding, the bubble instruction word and the reset PC.
package pipe_pkg;

   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_JR  = 2'b10;
   localparam logic [1:0] PCSRC_J   = 2'b11;

   typedef enum logic [1:0] {
      IF_IDLE  = 2'd0,
      IF_FETCH = 2'd1,
      IF_HOLD  = 2'd2
   } if_state_e;

   localparam logic [31:0] NOP_INST         = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/pipe_ifid_reg.sv
// IF/ID pipeline register: load a fetched word, insert a bubble, or hold.
// load has priority over bubble; neither means hold.
module pipe_ifid_reg
   import pipe_pkg::*;
(
   input  logic        clock,
   input  logic        resetn,
   input  logic        load,
   input  logic        bubble,
   input  logic [31:0] new_inst,
   input  logic [31:0] new_pc4,
   output logic [31:0] d_inst,
   output logic [31:0] d_pc4,
   output logic        d_valid
);

   // A bubble clears the instruction and valid bit but keeps d_pc4.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         d_inst  <= NOP_INST;
         d_pc4   <= 32'h0000_0000;
         d_valid <= 1'b0;
      end else if (load) begin
         d_inst  <= new_inst;
         d_pc4   <= new_pc4;
         d_valid <= 1'b1;
      end else if (bubble) begin
         d_inst  <= NOP_INST;
         d_valid <= 1'b0;
      end else begin
         d_inst  <= d_inst;
         d_pc4   <= d_pc4;
         d_valid <= d_valid;
      end
   end

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ready handshake
// and feeds the IF/ID register, honouring the single branch delay slot.
module pipe_if_stage
   import pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          IMEM_AW  = 32
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               nostall,
   input  logic [1:0]         pcsource,
   input  logic [31:0]        bpc,
   input  logic [31:0]        rpc,
   input  logic [31:0]        jpc,
   output logic               imem_req,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic               imem_ready,
   input  logic [31:0]        imem_rdata,
   output logic [31:0]        d_inst,
   output logic [31:0]        d_pc4,
   output logic               d_valid
);

   if_state_e   state_r;
   logic [31:0] pc_r;
   logic [31:0] hold_inst_r;
   logic [31:0] redir_pc_r;
   logic        redir_pend_r;

   logic        accept_s;
   logic        park_s;
   logic        redirect_s;
   logic [31:0] word_s;
   logic [31:0] target_s;
   logic [31:0] npc_s;
   logic [31:0] pc4_s;

   assign imem_addr = pc_r;
   assign pc4_s     = pc_plus4(pc_r);

   // Accept/park decode, redirect target and next-PC selection.
   always_comb begin
      accept_s = 1'b0;
      park_s   = 1'b0;
      word_s   = imem_rdata;
      target_s = bpc;
      npc_s    = pc4_s;

      case (pcsource)
         PCSRC_BR: target_s = bpc;
         PCSRC_JR: target_s = rpc;
         PCSRC_J:  target_s = jpc;
         default:  target_s = bpc;
      endcase

      redirect_s = d_valid & nostall & (pcsource != PCSRC_SEQ);

      case (state_r)
         IF_FETCH: begin
            accept_s = imem_ready & nostall;
            park_s   = imem_ready & ~nostall;
            word_s   = imem_rdata;
         end
         IF_HOLD: begin
            accept_s = nostall;
            park_s   = 1'b0;
            word_s   = hold_inst_r;
         end
         default: begin
            accept_s = 1'b0;
            park_s   = 1'b0;
            word_s   = imem_rdata;
         end
      endcase

      // The word accepted now is the delay slot, so the target follows it.
      if (redirect_s) begin
         npc_s = target_s;
      end else if (redir_pend_r) begin
         npc_s = redir_pc_r;
      end else begin
         npc_s = pc4_s;
      end
   end

   // Fetch FSM with registered request, PC, parked word and pending redirect.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_r      <= IF_IDLE;
         imem_req     <= 1'b0;
         pc_r         <= RESET_PC;
         hold_inst_r  <= 32'h0000_0000;
         redir_pc_r   <= 32'h0000_0000;
         redir_pend_r <= 1'b0;
      end else begin
         case (state_r)
            IF_IDLE: begin
               state_r  <= IF_FETCH;
               imem_req <= 1'b1;
            end
            IF_FETCH: begin
               if (accept_s) begin
                  pc_r <= npc_s;
               end else if (park_s) begin
                  hold_inst_r <= imem_rdata;
                  state_r     <= IF_HOLD;
                  imem_req    <= 1'b0;
               end else begin
                  pc_r <= pc_r;
               end
            end
            IF_HOLD: begin
               if (accept_s) begin
                  pc_r     <= npc_s;
                  state_r  <= IF_FETCH;
                  imem_req <= 1'b1;
               end else begin
                  state_r <= IF_HOLD;
               end
            end
            default: begin
               state_r  <= IF_IDLE;
               imem_req <= 1'b0;
            end
         endcase

         if (accept_s) begin
            redir_pend_r <= 1'b0;
         end else if (redirect_s) begin
            redir_pend_r <= 1'b1;
            redir_pc_r   <= target_s;
         end else begin
            redir_pend_r <= redir_pend_r;
         end
      end
   end

   pipe_ifid_reg u_ifid (
      .clock    (clock),
      .resetn   (resetn),
      .load     (accept_s),
      .bubble   (nostall & ~accept_s),
      .new_inst (word_s),
      .new_pc4  (pc4_s),
      .d_inst   (d_inst),
      .d_pc4    (d_pc4),
      .d_valid  (d_valid)
   );

endmodule
